// File: rtl/fft_mem_arbiter_if.sv
// Bundles the two requester ports, the memory command/return bus and the
// monitoring counters of the FFT sample-memory arbiter.
interface fft_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) ();
    logic                  eng_req_i;
    logic                  eng_we_i;
    logic [ADDR_WIDTH-1:0] eng_addr_i;
    logic [DATA_WIDTH-1:0] eng_wdata_i;
    logic                  eng_gnt_o;
    logic                  eng_rvalid_o;
    logic [DATA_WIDTH-1:0] eng_rdata_o;

    logic                  host_req_i;
    logic                  host_we_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [DATA_WIDTH-1:0] host_wdata_i;
    logic                  host_gnt_o;
    logic                  host_rvalid_o;
    logic [DATA_WIDTH-1:0] host_rdata_o;

    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_write_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic [3:0]            starve_cnt_o;
    logic [15:0]           conflict_cnt_o;

    modport slave (
        input  eng_req_i, eng_we_i, eng_addr_i, eng_wdata_i,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  mem_rdata_i,
        output eng_gnt_o, eng_rvalid_o, eng_rdata_o,
        output host_gnt_o, host_rvalid_o, host_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_write_o,
        output starve_cnt_o, conflict_cnt_o
    );

    modport master (
        output eng_req_i, eng_we_i, eng_addr_i, eng_wdata_i,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output mem_rdata_i,
        input  eng_gnt_o, eng_rvalid_o, eng_rdata_o,
        input  host_gnt_o, host_rvalid_o, host_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_write_o,
        input  starve_cnt_o, conflict_cnt_o
    );
endinterface

// File: rtl/fft_mem_arbiter.sv
// Single-port FFT sample-memory arbiter: engine has priority, host is forced a
// grant after STARVE_LIMIT lost cycles; read data is routed back to its issuer.
module fft_mem_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    fft_mem_arbiter_if.slave bus
);
    localparam logic [3:0]  LIMIT_C    = 4'(STARVE_LIMIT);
    localparam logic [15:0] CONF_MAX_C = 16'hFFFF;

    logic                  both_req_s;
    logic                  eng_gnt_s;
    logic                  host_gnt_s;
    logic                  any_gnt_s;
    logic                  win_we_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_wdata_s;

    logic [3:0]            starve_q,    starve_d;
    logic [15:0]           conflict_q,  conflict_d;
    logic                  eng_rd_q,    eng_rd_d;
    logic                  host_rd_q,   host_rd_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

    // Arbitration; grants are held off while reset is asserted.
    always_comb begin
        both_req_s = bus.eng_req_i & bus.host_req_i;
        eng_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
        if (!reset_n_i) begin
            eng_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end else if (both_req_s) begin
            if (starve_q >= LIMIT_C) begin
                host_gnt_s = 1'b1;
            end else begin
                eng_gnt_s = 1'b1;
            end
        end else if (bus.eng_req_i) begin
            eng_gnt_s = 1'b1;
        end else if (bus.host_req_i) begin
            host_gnt_s = 1'b1;
        end else begin
            eng_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end
        any_gnt_s = eng_gnt_s | host_gnt_s;
    end

    // Winner field mux.
    always_comb begin
        if (host_gnt_s) begin
            win_we_s    = bus.host_we_i;
            win_addr_s  = bus.host_addr_i;
            win_wdata_s = bus.host_wdata_i;
        end else if (eng_gnt_s) begin
            win_we_s    = bus.eng_we_i;
            win_addr_s  = bus.eng_addr_i;
            win_wdata_s = bus.eng_wdata_i;
        end else begin
            win_we_s    = 1'b0;
            win_addr_s  = last_addr_q;
            win_wdata_s = '0;
        end
    end

    // Next-state: starvation/conflict counters, read owner, address shadow.
    always_comb begin
        if (host_gnt_s) begin
            starve_d = 4'd0;
        end else if (both_req_s) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        if (both_req_s && (conflict_q != CONF_MAX_C)) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end

        eng_rd_d    = eng_gnt_s  & ~bus.eng_we_i;
        host_rd_d   = host_gnt_s & ~bus.host_we_i;
        last_addr_d = win_addr_s;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_q    <= 4'd0;
            conflict_q  <= 16'd0;
            eng_rd_q    <= 1'b0;
            host_rd_q   <= 1'b0;
            last_addr_q <= '0;
        end else begin
            starve_q    <= starve_d;
            conflict_q  <= conflict_d;
            eng_rd_q    <= eng_rd_d;
            host_rd_q   <= host_rd_d;
            last_addr_q <= last_addr_d;
        end
    end

    // Output drive; read data is shared and qualified only by rvalid.
    always_comb begin
        bus.eng_gnt_o      = eng_gnt_s;
        bus.host_gnt_o     = host_gnt_s;
        bus.mem_addr_o     = win_addr_s;
        bus.mem_wdata_o    = win_wdata_s;
        bus.mem_write_o    = win_we_s & any_gnt_s;
        bus.eng_rvalid_o   = eng_rd_q;
        bus.host_rvalid_o  = host_rd_q;
        bus.eng_rdata_o    = bus.mem_rdata_i;
        bus.host_rdata_o   = bus.mem_rdata_i;
        bus.starve_cnt_o   = starve_q;
        bus.conflict_cnt_o = conflict_q;
    end
endmodule

// File: tb/tb_fft_mem_arbiter.sv
// Self-checking bench for fft_mem_arbiter: directed table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_fft_mem_arbiter;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk_i;
    logic reset_n_i;
    int   n_tests;
    int   n_fail;

    fft_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fft_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory with one-cycle registered read.
    logic [DW-1:0] mem_arr [0:2047] = '{default: 32'h0};
    logic [DW-1:0] mem_rdata_q;
    always @(posedge clk_i) begin
        if (bus.mem_write_o) mem_arr[bus.mem_addr_o] <= bus.mem_wdata_o;
        mem_rdata_q <= mem_arr[bus.mem_addr_o];
    end
    assign bus.mem_rdata_i = mem_rdata_q;

    // Reference model state: memory image, counters, pending read per requester.
    logic [DW-1:0] ref_mem [0:2047] = '{default: 32'h0};
    int            m_starve;
    int            m_conflict;
    bit            m_eng_pend;
    bit            m_host_pend;
    logic [DW-1:0] m_rd_data;
    logic [AW-1:0] m_last_addr;
    bit            m_eg;
    bit            m_hg;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve    = 0;
        m_conflict  = 0;
        m_eng_pend  = 1'b0;
        m_host_pend = 1'b0;
        m_last_addr = '0;
        m_eg        = 1'b0;
        m_hg        = 1'b0;
    endtask

    // Predicts this cycle's outputs from the rules, compares, then advances.
    task automatic model_check();
        bit            both, eg, hg, wr, rd;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        both = bus.eng_req_i && bus.host_req_i;
        eg = 1'b0;
        hg = 1'b0;
        if (both) begin
            if (m_starve == LIMIT) hg = 1'b1; else eg = 1'b1;
        end else if (bus.eng_req_i) eg = 1'b1;
        else if (bus.host_req_i) hg = 1'b1;
        a  = eg ? bus.eng_addr_i : (hg ? bus.host_addr_i : m_last_addr);
        wd = eg ? bus.eng_wdata_i : bus.host_wdata_i;
        wr = (eg && bus.eng_we_i) || (hg && bus.host_we_i);
        rd = (eg || hg) && !wr;

        check("eng_gnt", {31'd0, bus.eng_gnt_o}, {31'd0, eg});
        check("host_gnt", {31'd0, bus.host_gnt_o}, {31'd0, hg});
        check("mem_addr", {21'd0, bus.mem_addr_o}, {21'd0, a});
        check("mem_write", {31'd0, bus.mem_write_o}, {31'd0, wr});
        if (wr) check("mem_wdata", bus.mem_wdata_o, wd);
        check("starve_cnt", {28'd0, bus.starve_cnt_o}, 32'(m_starve));
        check("conflict_cnt", {16'd0, bus.conflict_cnt_o}, 32'(m_conflict));
        check("eng_rvalid", {31'd0, bus.eng_rvalid_o}, {31'd0, m_eng_pend});
        check("host_rvalid", {31'd0, bus.host_rvalid_o}, {31'd0, m_host_pend});
        if (m_eng_pend) check("eng_rdata", bus.eng_rdata_o, m_rd_data);
        if (m_host_pend) check("host_rdata", bus.host_rdata_o, m_rd_data);

        if (hg) m_starve = 0;
        else if (both) m_starve = m_starve + 1;
        if (both && m_conflict < 65535) m_conflict = m_conflict + 1;
        m_eng_pend  = eg && !bus.eng_we_i;
        m_host_pend = hg && !bus.host_we_i;
        if (rd) m_rd_data = ref_mem[a];
        if (wr) ref_mem[a] = wd;
        if (eg || hg) m_last_addr = a;
        m_eg = eg;
        m_hg = hg;
    endtask

    // One bus cycle: drive after the edge, check at the falling edge.
    task automatic drive(input logic er, input logic ew, input logic [AW-1:0] ea,
                         input logic [DW-1:0] ed, input logic hr, input logic hw,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk_i);
        #1;
        bus.eng_req_i  = er;  bus.eng_we_i  = ew;  bus.eng_addr_i  = ea;  bus.eng_wdata_i  = ed;
        bus.host_req_i = hr;  bus.host_we_i = hw;  bus.host_addr_i = ha;  bus.host_wdata_i = hd;
        @(negedge clk_i);
        model_check();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 11'd0, 32'd0);
    endtask

    typedef struct {
        logic       eng_req;
        logic       host_req;
        logic       exp_eng;
        logic       exp_host;
        logic [3:0] exp_starve;
    } vec_t;
    vec_t tbl [16];

    initial begin
        logic          er, ew, hr, hw;
        logic [AW-1:0] ea, ha;
        logic [DW-1:0] ed, hd;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        n_tests = 0;
        n_fail  = 0;

        // Reset with both requesters active: grants must stay low.
        reset_n_i = 1'b0;
        bus.eng_req_i  = 1'b1; bus.eng_we_i  = 1'b1; bus.eng_addr_i  = 11'h155; bus.eng_wdata_i  = 32'hA5A5A5A5;
        bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 11'h2AA; bus.host_wdata_i = 32'h5A5A5A5A;
        #12;
        check("rst_eng_gnt", {31'd0, bus.eng_gnt_o}, 32'd0);
        check("rst_host_gnt", {31'd0, bus.host_gnt_o}, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write_o}, 32'd0);
        check("rst_mem_addr", {21'd0, bus.mem_addr_o}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        check("rst_rvalid", {30'd0, bus.eng_rvalid_o, bus.host_rvalid_o}, 32'd0);
        check("rst_starve", {28'd0, bus.starve_cnt_o}, 32'd0);
        check("rst_conflict", {16'd0, bus.conflict_cnt_o}, 32'd0);
        @(negedge clk_i);
        model_reset();
        bus.eng_req_i  = 1'b0;
        bus.host_req_i = 1'b0;
        reset_n_i = 1'b1;

        // Engine write then read-back.
        drive(1'b1, 1'b1, 11'h012, 32'hDEADBEEF, 1'b0, 1'b0, 11'd0, 32'd0);
        check("eng_wr_strobe", {31'd0, bus.mem_write_o}, 32'd1);
        drive(1'b1, 1'b0, 11'h012, 32'd0, 1'b0, 1'b0, 11'd0, 32'd0);
        check("eng_rd_strobe", {31'd0, bus.mem_write_o}, 32'd0);
        idle();
        check("eng_rd_valid", {31'd0, bus.eng_rvalid_o}, 32'd1);
        check("eng_rd_data", bus.eng_rdata_o, 32'hDEADBEEF);
        idle();
        check("eng_rd_single", {31'd0, bus.eng_rvalid_o}, 32'd0);

        // Starvation pattern and basic priority table.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].eng_req, 1'b0, 11'h005, 32'd0, tbl[i].host_req, 1'b0, 11'h006, 32'd0);
            check($sformatf("tbl%0d_eng_gnt", i), {31'd0, bus.eng_gnt_o}, {31'd0, tbl[i].exp_eng});
            check($sformatf("tbl%0d_host_gnt", i), {31'd0, bus.host_gnt_o}, {31'd0, tbl[i].exp_host});
            check($sformatf("tbl%0d_starve", i), {28'd0, bus.starve_cnt_o}, {28'd0, tbl[i].exp_starve});
        end

        // Read routing: engine read then host read on the next cycle.
        drive(1'b1, 1'b1, 11'h000, 32'h11111111, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b0, 1'b0, 11'h000, 32'd0, 1'b1, 1'b1, 11'h7FF, 32'h22222222);
        drive(1'b1, 1'b0, 11'h000, 32'd0, 1'b0, 1'b0, 11'h000, 32'd0);
        drive(1'b0, 1'b0, 11'h000, 32'd0, 1'b1, 1'b0, 11'h7FF, 32'd0);
        check("route_eng_valid", {30'd0, bus.eng_rvalid_o, bus.host_rvalid_o}, 32'd2);
        check("route_eng_data", bus.eng_rdata_o, 32'h11111111);
        idle();
        check("route_host_valid", {30'd0, bus.eng_rvalid_o, bus.host_rvalid_o}, 32'd1);
        check("route_host_data", bus.host_rdata_o, 32'h22222222);

        // Host idle while engine busy; a lone host request wins at once.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 11'(i), 32'd0, 1'b0, 1'b0, 11'd0, 32'd0);
        end
        check("idle_starve", {28'd0, bus.starve_cnt_o}, 32'd0);
        drive(1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 11'h003, 32'd0);
        check("idle_host_gnt", {31'd0, bus.host_gnt_o}, 32'd1);

        // Randomized traffic; pending requests stay stable until granted.
        er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        hr = 1'b0; hw = 1'b0; ha = '0; hd = '0;
        for (int c = 0; c < 600; c++) begin
            if (!(er && !m_eg)) begin
                er = 1'($urandom_range(0, 3) != 0);
                ew = 1'($urandom_range(0, 1));
                ea = 11'($urandom_range(0, 7));
                ed = $urandom;
            end
            if (!(hr && !m_hg)) begin
                hr = 1'($urandom_range(0, 1));
                hw = 1'($urandom_range(0, 1));
                ha = 11'($urandom_range(0, 7));
                hd = $urandom;
            end
            drive(er, ew, ea, ed, hr, hw, ha, hd);
        end

        // Reset lands while a read is in flight.
        drive(1'b1, 1'b0, 11'h012, 32'd0, 1'b1, 1'b0, 11'h013, 32'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        check("midrst_rvalid", {30'd0, bus.eng_rvalid_o, bus.host_rvalid_o}, 32'd0);
        check("midrst_conflict", {16'd0, bus.conflict_cnt_o}, 32'd0);
        check("midrst_starve", {28'd0, bus.starve_cnt_o}, 32'd0);
        model_reset();
        bus.eng_req_i  = 1'b0;
        bus.host_req_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
        end

        // Conflict counter saturation.
        for (int c = 0; c < 70000; c++) begin
            drive(1'b1, 1'b0, 11'h001, 32'd0, 1'b1, 1'b0, 11'h002, 32'd0);
        end
        check("sat_conflict", {16'd0, bus.conflict_cnt_o}, 32'h0000FFFF);
        idle();
        check("sat_hold", {16'd0, bus.conflict_cnt_o}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_mem_arbiter.md
Name: fft_mem_arbiter

Overview:
- Shares the single-port FFT sample memory (2048 x 32, one-cycle registered read) between two requesters.
  - FFT engine: high priority.
  - Host/DMA path: low priority, with starvation protection.
- Issues one memory command per cycle and routes read data back to the requester that issued it.
- Keeps a saturating conflict counter for performance monitoring.

Parameters:
- ADDR_WIDTH, 11: memory word address width (2048 words).
- DATA_WIDTH, 32: memory word width.
- STARVE_LIMIT, 4: consecutive host-losing cycles before the host is forced a grant (legal range 1..15).

Ports:
- clk_i  input  1  single clock for all logic.
- reset_n_i  input  1  asynchronous active-low reset.
- eng_req_i  input  1  engine request; held with stable fields until granted.
- eng_we_i  input  1  engine write (1) / read (0).
- eng_addr_i  input  ADDR_WIDTH  engine word address.
- eng_wdata_i  input  DATA_WIDTH  engine write data.
- eng_gnt_o  output  1  engine request accepted this cycle.
- eng_rvalid_o  output  1  engine read data valid.
- eng_rdata_o  output  DATA_WIDTH  engine read data.
- host_req_i, host_we_i, host_addr_i, host_wdata_i  input  1/1/ADDR_WIDTH/DATA_WIDTH  host request fields; same rules as engine.
- host_gnt_o, host_rvalid_o, host_rdata_o  output  1/1/DATA_WIDTH  host grant and read return.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_write_o  output  1  memory write strobe.
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid one cycle after the read address is presented.
- starve_cnt_o  output  4  current host starvation count.
- conflict_cnt_o  output  16  saturating count of cycles with both requests asserted.

Behaviour:
- Reset (asynchronous, reset_n_i low):
  - starve_cnt and conflict_cnt clear to 0.
  - Read-owner pipeline clears; eng_rvalid_o = host_rvalid_o = 0.
  - Grants are forced to 0; mem_write_o = 0; mem_addr_o and mem_wdata_o are 0.
- Arbitration is combinational within the cycle; exactly one or zero grants per cycle.
  - Only engine requests: engine granted.
  - Only host requests: host granted.
  - Both request and starve_cnt < STARVE_LIMIT: engine granted; starve_cnt increments.
  - Both request and starve_cnt == STARVE_LIMIT: host granted (forced).
  - Any host grant clears starve_cnt to 0.
  - Host not requesting: starve_cnt holds.
- Grant handshake:
  - A request is consumed at the clock edge where gnt is 1.
  - A requester keeps req and fields stable while gnt is 0.
  - A requester may deassert after the grant, or issue back-to-back requests.
- Memory command: the winner's address and wdata drive mem_addr_o / mem_wdata_o. mem_write_o = winner_we & grant.
  - With no grant: mem_write_o = 0 and mem_addr_o holds the last granted address (registered shadow), to avoid toggling.
- Read return:
  - The read owner (engine/host/none) is registered at a granted read.
  - Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata_i. The other rvalid stays 0.
  - Read latency from grant edge: exactly 1 cycle. Throughput: 1 access per cycle.
- Writes produce no rvalid.
- Ordering:
  - A read granted in the cycle after a write to the same address returns the new data; the memory is write-before-read over a cycle boundary.
  - Same-cycle read/write conflicts cannot occur (one grant only).
- conflict_cnt increments when eng_req_i & host_req_i and saturates at 16'hFFFF; no wrap.
- Reset mid-operation: an in-flight read is discarded, no rvalid after reset release, and counters restart from 0.
- rdata outputs need not be zeroed when rvalid = 0; they are only qualified by rvalid.

Test Plan:
- Reset: assert reset_n_i low mid-read, release -> all gnt/rvalid/mem_write_o are 0, starve_cnt_o = 0, conflict_cnt_o = 0, no stray rvalid.
- Engine only: write 0xDEADBEEF to 0x012, then read 0x012 -> eng_gnt_o each cycle, mem_write_o = 1 then 0, eng_rvalid_o = 1 one cycle after the read grant with eng_rdata_o = 0xDEADBEEF.
- Starvation (STARVE_LIMIT = 4): engine and host both continuously request -> grant pattern E,E,E,E,H repeating; starve_cnt_o runs 0,1,2,3,4,0; conflict_cnt_o increments every cycle.
- Read routing: engine read 0x000 in cycle n, host read 0x7FF in cycle n+1 -> eng_rvalid_o only at n+1, host_rvalid_o only at n+2, each carrying its own address's data.
- Host idle while engine busy for 10 cycles -> starve_cnt_o stays 0; a host request then arriving with no engine request is granted in the same cycle.
- Saturation: force 70000 conflict cycles -> conflict_cnt_o holds at 0xFFFF with no wrap.
